output_processor: RTL and testbench
===================================

Name: output_processor

Overview:
- Formats one calculator result into ASCII and writes it byte-by-byte into the UART TX FIFO. It is the transmit-side counterpart of the RX-side command parser.
- Accepts a 16-bit magnitude, a sign flag and an error flag from the calculation unit.
- Emits optional '-', decimal digits without leading zeros, then CR LF. An error flag emits "ERR" CR LF instead.
- Sits between the arithmetic core and the TX FIFO, and signals completion to the top-level controller.

Parameters:
- DATA_WIDTH, 8, TX FIFO data width; only 8 is supported.
- RESULT_WIDTH, 16, magnitude width; the maximum printable value is 65535 (5 digits).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- result_i  input  16  unsigned magnitude of the result
- neg_i  input  1  result is negative
- err_i  input  1  error (e.g. divide by zero); overrides result_i/neg_i
- result_valid_i  input  1  one-cycle strobe; inputs are valid
- ready_o  output  1  high only in IDLE; result can be accepted
- tx_full_in  input  1  TX FIFO full
- tx_wen_o  output  1  TX FIFO write enable, one byte per cycle max
- tx_data_o  output  DATA_WIDTH  byte written when tx_wen_o=1
- done_o  output  1  one-cycle pulse after the final LF is written

Behaviour:
- Reset values: ready_o=1, tx_wen_o=0, tx_data_o=8'h00, done_o=0, state=IDLE, internal registers cleared.
- Reset asserted mid-operation aborts the sequence immediately. No further writes occur, no done_o pulse is produced, and the next cycle after release is IDLE.
- All outputs are registered.
- IDLE:
  - ready_o=1.
  - On result_valid_i=1, capture result_i, neg_i and err_i.
  - Go to SEND_ERR if err_i=1, else CONVERT.
- Strobes are ignored outside IDLE: result_valid_i while ready_o=0 is dropped, and captured data never changes.
- CONVERT:
  - Pulse start to bin2bcd for 1 cycle.
  - Wait for its done (16 shift iterations + 1 cycle, fixed latency).
  - Then latch the 5 BCD digits.
  - Compute the leading-digit index = position of the first nonzero digit. A value of 0 gives index = units, so it prints "0".
- SEND_SIGN:
  - Entered only if neg=1 and magnitude≠0. Negative zero prints "0" with no sign.
  - Writes 8'h2D ('-').
- SEND_DIGIT:
  - Writes 8'h30+digit, from the leading-digit index down to units, one digit per successful write.
- SEND_CR writes 8'h0D; SEND_LF writes 8'h0A.
- SEND_ERR writes 'E','R','R' (8'h45, 8'h52, 8'h52), then goes to SEND_CR.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Write rule, every SEND_* state:
  - If tx_full_in=0 in a cycle, the next edge registers tx_wen_o=1 with the current byte and advances to the next byte.
  - If tx_full_in=1, the next edge registers tx_wen_o=0 and holds the state and byte.
  - tx_wen_o is never high for two cycles carrying the same byte.
  - No byte is lost or duplicated across any number of full cycles.
- tx_data_o holds its last value when tx_wen_o=0.
- Latency with the FIFO never full, for an N-byte message (sign + digits + CR + LF):
  - first write 19 cycles after the accepting edge;
  - one byte per cycle thereafter;
  - done_o one cycle after the LF write;
  - ready_o high the cycle after done_o.
- Error latency: first write 2 cycles after the accepting edge.

Decomposition:
- calc_pkg (shared with the parser) holds:
  - ASCII constants: CHAR_0, CHAR_MINUS, CHAR_CR, CHAR_LF, CHAR_E, CHAR_R;
  - op-code typedef op_e (ADD=00, SUB=01, MUL=10, DIV=11);
  - out_state_e enum (IDLE, CONVERT, SEND_SIGN, SEND_DIGIT, SEND_CR, SEND_LF, SEND_ERR, DONE).
- Sub-module bin2bcd: sequential double-dabble.
  - Ports: clk, rst, start_i, bin_i[15:0], bcd_o[19:0], done_o.
  - Fixed 17-cycle latency.
  - Independently testable and reusable.

Test Plan:
- result=20, neg=0, FIFO empty → bytes 32 30 0D 0A on consecutive cycles, single done_o pulse, ready_o returns high.
- result=0, neg=1 → bytes 30 0D 0A (no '-').
- result=65535 → 36 35 35 33 35 0D 0A; result=7, neg=1 → 2D 37 0D 0A.
- err=1 with result=123 → 45 52 52 0D 0A, first write 2 cycles after accept; result ignored.
- result=1500, tx_full_in forced high for 5 cycles after the second byte → tx_wen_o low during the stall; full sequence 31 35 30 30 0D 0A intact, no duplicates.
- Two further cases:
  - result_valid_i with result=9 pulsed mid-transmission → ignored, original message unchanged.
  - rst pulsed mid-digit → writes stop next cycle, no done_o, and a following result=3 prints 33 0D 0A.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: ASCII codes, op-codes, output FSM states
// and a helper that locates the most significant nonzero BCD digit.
package calc_pkg;

  localparam logic [7:0] CHAR_0     = 8'h30;
  localparam logic [7:0] CHAR_MINUS = 8'h2D;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_E     = 8'h45;
  localparam logic [7:0] CHAR_R     = 8'h52;

  localparam int BCD_DIGITS = 5;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    SEND_SIGN,
    SEND_DIGIT,
    SEND_CR,
    SEND_LF,
    SEND_ERR,
    DONE
  } out_state_e;

  // Index of the highest nonzero digit; an all-zero value still yields the
  // units position so that zero prints as a single "0".
  function automatic logic [2:0] lead_index(input logic [4*BCD_DIGITS-1:0] bcd);
    lead_index = 3'd0;
    for (int i = 1; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        lead_index = 3'(i);
      end
    end
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: 16-bit binary to 5 BCD digits.
// The start cycle loads the operand, then 16 add-3/shift steps follow;
// done_o rises 17 cycles after start_i was raised and bcd_o then holds the
// result until the next start.
module bin2bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic [19:0] bcd_o,
  output logic        done_o
);

  logic [15:0] bin_q;
  logic [19:0] bcd_q;
  logic [3:0]  count_q;
  logic        busy_q;
  logic [19:0] adj;

  // Add 3 to every digit that is 5 or more before it is doubled.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Load on start, then shift one binary bit into the BCD field per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        bin_q   <= bin_i;
        bcd_q   <= '0;
        count_q <= '0;
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        {bcd_q, bin_q} <= {adj[18:0], bin_q, 1'b0};
        count_q        <= count_q + 4'd1;
        if (count_q == 4'd15) begin
          busy_q <= 1'b0;
          done_o <= 1'b1;
        end
      end
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/output_processor.sv
// Turns one calculator result into ASCII ("-", digits, CR LF or "ERR" CR LF)
// and writes it byte by byte into the UART TX FIFO, honouring FIFO full.
module output_processor
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RESULT_WIDTH-1:0] result_i,
  input  logic                    neg_i,
  input  logic                    err_i,
  input  logic                    result_valid_i,
  output logic                    ready_o,
  input  logic                    tx_full_in,
  output logic                    tx_wen_o,
  output logic [DATA_WIDTH-1:0]   tx_data_o,
  output logic                    done_o
);

  out_state_e       state;
  logic             neg_q;
  logic [4:0][3:0]  digits_q;
  logic [2:0]       idx_q;
  logic [1:0]       err_idx_q;

  logic             bcd_start;
  logic             bcd_done;
  logic [19:0]      bcd_val;

  // The converter is started on the accepting edge itself and its load
  // register keeps the captured magnitude, so no separate copy is needed.
  assign bcd_start = ready_o && result_valid_i && !err_i;

  bin2bcd u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (bcd_start),
    .bin_i   (result_i),
    .bcd_o   (bcd_val),
    .done_o  (bcd_done)
  );

  // Output sequencer: every SEND state writes at most one byte per cycle and
  // only advances when the FIFO had room in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready_o   <= 1'b1;
      tx_wen_o  <= 1'b0;
      tx_data_o <= '0;
      done_o    <= 1'b0;
      neg_q     <= 1'b0;
      digits_q  <= '0;
      idx_q     <= '0;
      err_idx_q <= '0;
    end else begin
      tx_wen_o <= 1'b0;
      done_o   <= 1'b0;
      case (state)
        IDLE: begin
          ready_o <= 1'b1;
          if (ready_o && result_valid_i) begin
            ready_o   <= 1'b0;
            neg_q     <= neg_i;
            err_idx_q <= 2'd0;
            state     <= err_i ? SEND_ERR : CONVERT;
          end
        end
        CONVERT: begin
          if (bcd_done) begin
            digits_q <= bcd_val;
            idx_q    <= lead_index(bcd_val);
            state    <= (neg_q && bcd_val != 20'd0) ? SEND_SIGN : SEND_DIGIT;
          end
        end
        SEND_SIGN: begin
          if (!tx_full_in) begin
            tx_wen_o  <= 1'b1;
            tx_data_o <= CHAR_MINUS;
            state     <= SEND_DIGIT;
          end
        end
        SEND_DIGIT: begin
          if (!tx_full_in) begin
            tx_wen_o  <= 1'b1;
            tx_data_o <= CHAR_0 + {4'h0, digits_q[idx_q]};
            if (idx_q == 3'd0) begin
              state <= SEND_CR;
            end else begin
              idx_q <= idx_q - 3'd1;
            end
          end
        end
        SEND_ERR: begin
          if (!tx_full_in) begin
            tx_wen_o  <= 1'b1;
            tx_data_o <= (err_idx_q == 2'd0) ? CHAR_E : CHAR_R;
            if (err_idx_q == 2'd2) begin
              state <= SEND_CR;
            end else begin
              err_idx_q <= err_idx_q + 2'd1;
            end
          end
        end
        SEND_CR: begin
          if (!tx_full_in) begin
            tx_wen_o  <= 1'b1;
            tx_data_o <= CHAR_CR;
            state     <= SEND_LF;
          end
        end
        SEND_LF: begin
          if (!tx_full_in) begin
            tx_wen_o  <= 1'b1;
            tx_data_o <= CHAR_LF;
            state     <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_processor.sv
// Scoreboard bench for output_processor: directed results push their
// hand-computed byte streams into a queue and a monitor pops and compares
// every byte the DUT writes to the TX FIFO.
module tb_output_processor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] result_i = '0;
  logic        neg_i = 1'b0;
  logic        err_i = 1'b0;
  logic        result_valid_i = 1'b0;
  logic        ready_o;
  logic        tx_full_in = 1'b0;
  logic        tx_wen_o;
  logic [7:0]  tx_data_o;
  logic        done_o;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  int          acc_cyc = 0;
  bit          first_seen = 1'b0;
  int          first_lat = 0;
  int          last_wen_cyc = 0;
  int          gap_count = 0;
  int          done_count = 0;

  output_processor #(.DATA_WIDTH(8), .RESULT_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .result_i       (result_i),
    .neg_i          (neg_i),
    .err_i          (err_i),
    .result_valid_i (result_valid_i),
    .ready_o        (ready_o),
    .tx_full_in     (tx_full_in),
    .tx_wen_o       (tx_wen_o),
    .tx_data_o      (tx_data_o),
    .done_o         (done_o)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Edge counter used to measure latencies.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Monitor: pop the scoreboard on every FIFO write and track timing.
  always @(negedge clk) begin
    if (tx_wen_o) begin
      if (!first_seen) begin
        first_seen = 1'b1;
        first_lat  = cyc + 1 - acc_cyc;
      end else if (cyc != last_wen_cyc + 1) begin
        gap_count++;
      end
      last_wen_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write got=%0h expected=none", tx_data_o);
      end else begin
        checkOutput("tx_byte", {24'h0, tx_data_o}, {24'h0, exp_q.pop_front()});
      end
    end
    if (done_o) done_count++;
  end

  task automatic pushExp(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic applyStimulus(input logic [15:0] r, input logic n, input logic e);
    int w = 0;
    while (!ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ready_o) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout got=0 expected=1");
    end
    first_seen     = 1'b0;
    gap_count      = 0;
    result_i       = r;
    neg_i          = n;
    err_i          = e;
    result_valid_i = 1'b1;
    acc_cyc        = cyc + 1;
    @(negedge clk);
    result_valid_i = 1'b0;
  endtask

  // Wait for done_o, then check timing, single pulse and ready return.
  task automatic waitDone(input string name, input int lat, input bit consec);
    int w = 0;
    while (!done_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!done_o) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_done_timeout got=0 expected=1", name);
      return;
    end
    checkOutput({name, "_done_after_lf"}, cyc - last_wen_cyc, 1);
    checkOutput({name, "_queue_empty"}, exp_q.size(), 0);
    if (lat >= 0) checkOutput({name, "_first_latency"}, first_lat, lat);
    if (consec) checkOutput({name, "_gaps"}, gap_count, 0);
    @(negedge clk);
    checkOutput({name, "_done_single"}, {31'h0, done_o}, 0);
    checkOutput({name, "_ready_back"}, {31'h0, ready_o}, 1);
  endtask

  task automatic waitWrites(input int n);
    int seen = 0;
    int w = 0;
    while (seen < n && w < 100) begin
      @(negedge clk);
      if (tx_wen_o) seen++;
      w++;
    end
    if (seen < n) begin
      checks++;
      failures++;
      $display("[TB] FAIL write_wait_timeout got=%0d expected=%0d", seen, n);
    end
  endtask

  // Global watchdog.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'h0, ready_o}, 1);
    checkOutput("reset_wen", {31'h0, tx_wen_o}, 0);
    checkOutput("reset_data", {24'h0, tx_data_o}, 0);
    checkOutput("reset_done", {31'h0, done_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] case 20");
    pushExp(8'h32); pushExp(8'h30); pushExp(8'h0D); pushExp(8'h0A);
    applyStimulus(16'd20, 1'b0, 1'b0);
    waitDone("r20", 19, 1'b1);

    $display("[TB] case negative zero");
    pushExp(8'h30); pushExp(8'h0D); pushExp(8'h0A);
    applyStimulus(16'd0, 1'b1, 1'b0);
    waitDone("negzero", 19, 1'b1);

    $display("[TB] case 65535");
    pushExp(8'h36); pushExp(8'h35); pushExp(8'h35); pushExp(8'h33);
    pushExp(8'h35); pushExp(8'h0D); pushExp(8'h0A);
    applyStimulus(16'd65535, 1'b0, 1'b0);
    waitDone("r65535", 19, 1'b1);

    $display("[TB] case -7");
    pushExp(8'h2D); pushExp(8'h37); pushExp(8'h0D); pushExp(8'h0A);
    applyStimulus(16'd7, 1'b1, 1'b0);
    waitDone("neg7", 19, 1'b1);

    $display("[TB] case error");
    pushExp(8'h45); pushExp(8'h52); pushExp(8'h52); pushExp(8'h0D); pushExp(8'h0A);
    applyStimulus(16'd123, 1'b0, 1'b1);
    waitDone("err", 2, 1'b1);

    $display("[TB] case 1500 with stall");
    pushExp(8'h31); pushExp(8'h35); pushExp(8'h30); pushExp(8'h30);
    pushExp(8'h0D); pushExp(8'h0A);
    applyStimulus(16'd1500, 1'b0, 1'b0);
    waitWrites(2);
    tx_full_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_wen_low", {31'h0, tx_wen_o}, 0);
    end
    tx_full_in = 1'b0;
    waitDone("stall", 19, 1'b0);

    $display("[TB] case strobe during transmission");
    pushExp(8'h36); pushExp(8'h35); pushExp(8'h35); pushExp(8'h33);
    pushExp(8'h35); pushExp(8'h0D); pushExp(8'h0A);
    applyStimulus(16'd65535, 1'b0, 1'b0);
    waitWrites(2);
    d0 = done_count;
    result_i = 16'd9;
    result_valid_i = 1'b1;
    @(negedge clk);
    result_valid_i = 1'b0;
    waitDone("strobe", 19, 1'b1);
    repeat (25) @(negedge clk);
    checkOutput("strobe_one_done", done_count - d0, 1);
    checkOutput("strobe_ready_idle", {31'h0, ready_o}, 1);

    $display("[TB] case reset mid-digit");
    pushExp(8'h36); pushExp(8'h35); pushExp(8'h35); pushExp(8'h33);
    pushExp(8'h35); pushExp(8'h0D); pushExp(8'h0A);
    applyStimulus(16'd65535, 1'b0, 1'b0);
    waitWrites(2);
    d0 = done_count;
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    checkOutput("rst_wen_stops", {31'h0, tx_wen_o}, 0);
    checkOutput("rst_ready", {31'h0, ready_o}, 1);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("rst_no_done", done_count - d0, 0);
    checkOutput("rst_idle_ready", {31'h0, ready_o}, 1);
    pushExp(8'h33); pushExp(8'h0D); pushExp(8'h0A);
    applyStimulus(16'd3, 1'b0, 1'b0);
    waitDone("after_rst", 19, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
